// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with 16x oversampling, mid-bit start check, framing/overrun detection
// and a valid/ready holding register. Define UART_RX_PARITY_EN for 8E1 with parity checking.
module uart_rx_deframer #(
   parameter int unsigned DIV        = 54,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       ser_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
   localparam int unsigned MID   = OVERSAMPLE / 2 - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PAR,
`endif
      S_STOP,
      S_BRK
   } state_e;

   state_e             state_q, state_d;
   logic               rx_meta_q, rx_meta_d;
   logic               rx_s_q, rx_s_d;
   logic [1:0]         sync_vld_q, sync_vld_d;
   logic               armed_q, armed_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [PH_W-1:0]    ph_q, ph_d;
   logic [2:0]         n_q, n_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               frame_err_q, frame_err_d;
   logic               overrun_q, overrun_d;
   logic               busy_q, busy_d;
   logic               tick, mid, deliver;
`ifdef UART_RX_PARITY_EN
   logic               par_bad_q, par_bad_d;
   logic               parity_err_q, parity_err_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q     <= S_IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         sync_vld_q  <= 2'b00;
         armed_q     <= 1'b0;
         div_q       <= '0;
         ph_q        <= '0;
         n_q         <= 3'd0;
         shift_q     <= 8'd0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         sync_vld_q  <= sync_vld_d;
         armed_q     <= armed_d;
         div_q       <= div_d;
         ph_q        <= ph_d;
         n_q         <= n_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      // Sync pipeline; arming waits until a real post-reset sample shows the line high
      rx_meta_d  = ser_rx;
      rx_s_d     = rx_meta_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
      armed_d    = armed_q | (sync_vld_q[1] & rx_s_q);

      tick  = (div_q == DIV_W'(DIV - 1));
      div_d = tick ? '0 : div_q + DIV_W'(1);
      ph_d  = ph_q;
      if (tick) begin
         ph_d = (ph_q == PH_W'(OVERSAMPLE - 1)) ? '0 : ph_q + PH_W'(1);
      end
      mid = tick && (ph_q == PH_W'(MID));

      case (state_q)
         S_IDLE: begin
            if (armed_q && !rx_s_q) begin
               state_d = S_START;
               div_d   = '0;
               ph_d    = '0;
            end
         end
         S_START: begin
            if (mid) begin
               state_d = rx_s_q ? S_IDLE : S_DATA;
               n_d     = 3'd0;
            end
         end
         S_DATA: begin
            if (mid) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               n_d     = n_q + 3'd1;
               if (n_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PAR: begin
            if (mid) begin
               par_bad_d = rx_s_q ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (mid) begin
               if (rx_s_q) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BRK;
               end
            end
         end
         S_BRK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Holding register: a same-cycle drain makes room for the new byte
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
`ifdef UART_RX_PARITY_EN
         parity_err_d = par_bad_q;
`endif
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
